// File: rtl/alu_issue_ctrl.sv
// Issue controller for the external combinational 16-bit ALU: READ -> EXEC -> WB per instruction.
// Optional macro ALU_ISSUE_FLAGS_EN adds flag_z / flag_c outputs, updated on writeback.
module alu_issue_ctrl #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [DATA_W-1:0]     rsdata,
  output logic [DATA_W-1:0]     rmdata,
  output logic [DATA_W-1:0]     N,
  output logic                  instr_bit_15,
  output logic [1:0]            instr_bit_12_11,
  input  logic [DATA_W-1:0]     aluout,
  output logic [DATA_W-1:0]     result,
  output logic                  done,
  output logic                  err,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic                  flag_z,
  output logic                  flag_c,
`endif
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int NREG = 2 ** REG_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]     rf [NREG];
  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q, rm_q;
  logic [7:0]            imm_q;
  logic [DATA_W-1:0]     result_q;
  logic [2:0]            in_op;
  logic                  in_legal;

  // opcodes 101 and 111 are the only holes in the map
  assign in_op    = {instr[15], instr[12:11]};
  assign in_legal = (instr[14:13] == 2'b00) && !(in_op[2] && in_op[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (instr_valid) state_d = in_legal ? S_READ : S_ERR;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign instr_ready = (state_q == S_IDLE) && !reset;
  assign done        = (state_q == S_WB);
  assign err         = (state_q == S_ERR);
  assign dbg_data    = rf[dbg_addr];

`ifdef ALU_ISSUE_FLAGS_EN
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W:0]   sum_ext;

  // Carry is rebuilt from the registered ALU-port values, not taken from the ALU.
  always_comb begin
    opnd_b  = instr_bit_12_11[0] ? N : rmdata;
    sum_ext = {1'b0, rsdata} + {1'b0, opnd_b};
    carry_d = 1'b0;
    case ({instr_bit_15, instr_bit_12_11[1]})
      2'b00:   carry_d = sum_ext[DATA_W];
      2'b01:   carry_d = (rsdata >= opnd_b);
      2'b10:   carry_d = rsdata[DATA_W-1];
      default: carry_d = rsdata[0];
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q            <= '0;
      rd_q            <= '0;
      rm_q            <= '0;
      imm_q           <= '0;
      rsdata          <= '0;
      rmdata          <= '0;
      N               <= '0;
      instr_bit_15    <= 1'b0;
      instr_bit_12_11 <= '0;
      result_q        <= '0;
      result          <= '0;
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
      carry_q         <= 1'b0;
      flag_z          <= 1'b0;
      flag_c          <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_q  <= in_op;
            rd_q  <= REG_ADDR_W'(instr[10:8]);
            rm_q  <= REG_ADDR_W'(instr[7:5]);
            imm_q <= instr[7:0];
          end
        end
        S_READ: begin
          rsdata          <= rf[rd_q];
          rmdata          <= rf[rm_q];
          N               <= DATA_W'(imm_q);
          instr_bit_15    <= op_q[2];
          instr_bit_12_11 <= op_q[1:0];
        end
        S_EXEC: begin
          result_q <= aluout;
`ifdef ALU_ISSUE_FLAGS_EN
          carry_q  <= carry_d;
`endif
        end
        S_WB: begin
          rf[rd_q] <= result_q;
          result   <= result_q;
`ifdef ALU_ISSUE_FLAGS_EN
          flag_z   <= (result_q == '0);
          flag_c   <= carry_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl; includes a behavioural model of the external ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] rsdata, rmdata, N;
  logic        instr_bit_15;
  logic [1:0]  instr_bit_12_11;
  logic [15:0] aluout;
  logic [15:0] result;
  logic        done, err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
  logic        flag_z, flag_c;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ALU: shifts move by one position
  always_comb begin
    case ({instr_bit_15, instr_bit_12_11})
      3'b000:  aluout = rsdata + rmdata;
      3'b001:  aluout = rsdata + N;
      3'b010:  aluout = rsdata - rmdata;
      3'b011:  aluout = rsdata - N;
      3'b100:  aluout = rsdata << 1;
      3'b110:  aluout = rsdata >> 1;
      default: aluout = rsdata;
    endcase
  end

  alu_issue_ctrl #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rsdata(rsdata), .rmdata(rmdata), .N(N),
    .instr_bit_15(instr_bit_15), .instr_bit_12_11(instr_bit_12_11),
    .aluout(aluout), .result(result), .done(done), .err(err),
`ifdef ALU_ISSUE_FLAGS_EN
    .flag_z(flag_z), .flag_c(flag_c),
`endif
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Issues one instruction; reports the cycle offsets (after the accepting edge) of done, err, ready.
  task automatic send(input logic [15:0] w, output int t_done, output int t_err, output int t_rdy);
    int tries;
    tries = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = w;
    while (!instr_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    @(posedge clk);
    t_done = -1; t_err = -1; t_rdy = -1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      if (done && t_done < 0) t_done = k;
      if (err && t_err < 0) t_err = k;
      if (instr_ready && t_rdy < 0) t_rdy = k;
    end
  endtask

  task automatic test_reset();
    logic seen_done;
    logic any_nz;
    int td, te, tr;
    reset = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_low: got %b want 0", instr_ready); end
    n_cmp++; if ({done, err, result} !== 18'h0) begin n_bad++; $display("FAIL rst_outs: got %h want 0", {done, err, result}); end
    reset = 1'b0;
    #1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_rel: got %b want 1", instr_ready); end

    send(16'h0905, td, te, tr);               // ADDI r1,#5
    // SUBI r1,#1 interrupted by reset while in EXEC
    @(negedge clk);
    instr_valid = 1'b1; instr = 16'h1901;
    @(posedge clk);
    @(negedge clk); instr_valid = 1'b0;       // READ
    @(negedge clk);                           // EXEC
    n_cmp++; if (rsdata !== 16'h0005) begin n_bad++; $display("FAIL exec_rsdata: got %h want 0005", rsdata); end
    reset = 1'b1;
    dbg_addr = 3'd1;
    #1;
    n_cmp++; if ({rsdata, rmdata, N, instr_bit_15, instr_bit_12_11, result, done, err} !== 69'h0) begin
      n_bad++; $display("FAIL midexec_outs: got %h want 0", {rsdata, rmdata, N, instr_bit_15, instr_bit_12_11, result, done, err}); end
    n_cmp++; if (dbg_data !== 16'h0000) begin n_bad++; $display("FAIL midexec_r1: got %h want 0000", dbg_data); end
`ifdef ALU_ISSUE_FLAGS_EN
    n_cmp++; if ({flag_z, flag_c} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b want 00", {flag_z, flag_c}); end
`endif
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL midexec_ready: got %b want 1", instr_ready); end
    @(negedge clk);
    if (done) seen_done = 1'b1;
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL midexec_nodone: got %b want 0", seen_done); end
    any_nz = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      if (dbg_data !== 16'h0) any_nz = 1'b1;
    end
    n_cmp++; if (any_nz !== 1'b0) begin n_bad++; $display("FAIL rst_rf_clear: got %b want 0", any_nz); end
  endtask

  task automatic test_add();
    int td, te, tr;
    send(16'h0905, td, te, tr);               // ADDI r1,#5
    dbg_addr = 3'd1; #1;
    n_cmp++; if (td !== 3) begin n_bad++; $display("FAIL addi_done_lat: got %0d want 3", td); end
    n_cmp++; if (dbg_data !== 16'h0005) begin n_bad++; $display("FAIL addi_r1: got %h want 0005", dbg_data); end
    n_cmp++; if (tr !== 4) begin n_bad++; $display("FAIL addi_ready_lat: got %0d want 4", tr); end
    send(16'h0120, td, te, tr);               // ADDR r1,r1
    dbg_addr = 3'd1; #1;
    n_cmp++; if (td !== 3) begin n_bad++; $display("FAIL addr_done_lat: got %0d want 3", td); end
    n_cmp++; if (dbg_data !== 16'h000A) begin n_bad++; $display("FAIL addr_r1: got %h want 000a", dbg_data); end
    n_cmp++; if (result !== 16'h000A) begin n_bad++; $display("FAIL addr_result: got %h want 000a", result); end
  endtask

  task automatic test_sub_wrap();
    int td, te, tr;
    send(16'h1A01, td, te, tr);               // SUBI r2,#1 with r2=0
    dbg_addr = 3'd2; #1;
    n_cmp++; if (result !== 16'hFFFF) begin n_bad++; $display("FAIL subi_result: got %h want ffff", result); end
    n_cmp++; if (dbg_data !== 16'hFFFF) begin n_bad++; $display("FAIL subi_r2: got %h want ffff", dbg_data); end
`ifdef ALU_ISSUE_FLAGS_EN
    n_cmp++; if ({flag_z, flag_c} !== 2'b00) begin n_bad++; $display("FAIL subi_flags: got %b want 00", {flag_z, flag_c}); end
`endif
  endtask

  task automatic test_shift();
    int td, te, tr;
    send(16'h0B80, td, te, tr);               // ADDI r3,#0x80
    repeat (8) send(16'h8300, td, te, tr);    // LSL r3 -> 0x8000
    send(16'h0B01, td, te, tr);               // ADDI r3,#1 -> 0x8001
    dbg_addr = 3'd3; #1;
    n_cmp++; if (dbg_data !== 16'h8001) begin n_bad++; $display("FAIL shift_setup_r3: got %h want 8001", dbg_data); end
    send(16'h8300, td, te, tr);               // LSL r3
    n_cmp++; if (result !== 16'h0002) begin n_bad++; $display("FAIL lsl_result: got %h want 0002", result); end
`ifdef ALU_ISSUE_FLAGS_EN
    n_cmp++; if (flag_c !== 1'b1) begin n_bad++; $display("FAIL lsl_carry: got %b want 1", flag_c); end
`endif
    send(16'h9300, td, te, tr);               // LSR r3
    dbg_addr = 3'd3; #1;
    n_cmp++; if (result !== 16'h0001) begin n_bad++; $display("FAIL lsr_result: got %h want 0001", result); end
    n_cmp++; if (dbg_data !== 16'h0001) begin n_bad++; $display("FAIL lsr_r3: got %h want 0001", dbg_data); end
`ifdef ALU_ISSUE_FLAGS_EN
    n_cmp++; if (flag_c !== 1'b0) begin n_bad++; $display("FAIL lsr_carry: got %b want 0", flag_c); end
`endif
  endtask

  task automatic test_zero();
    int td, te, tr;
    send(16'h1480, td, te, tr);               // SUBR r4,r4 with r4=0
    n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL subr_zero_result: got %h want 0000", result); end
    n_cmp++; if (td !== 3) begin n_bad++; $display("FAIL subr_done_lat: got %0d want 3", td); end
`ifdef ALU_ISSUE_FLAGS_EN
    n_cmp++; if ({flag_z, flag_c} !== 2'b11) begin n_bad++; $display("FAIL subr_flags: got %b want 11", {flag_z, flag_c}); end
`endif
  endtask

  task automatic test_illegal();
    int td, te, tr;
    logic [15:0] vec [2];
    vec[0] = 16'hA800;
    vec[1] = 16'h2000;
    for (int v = 0; v < 2; v++) begin
      send(vec[v], td, te, tr);
      n_cmp++; if (te !== 1) begin n_bad++; $display("FAIL illegal%0d_err_lat: got %0d want 1", v, te); end
      n_cmp++; if (td !== -1) begin n_bad++; $display("FAIL illegal%0d_nodone: got %0d want -1", v, td); end
      n_cmp++; if (tr !== 2) begin n_bad++; $display("FAIL illegal%0d_ready_lat: got %0d want 2", v, tr); end
      n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL illegal%0d_result: got %h want 0000", v, result); end
      dbg_addr = 3'd0; #1;
      n_cmp++; if (dbg_data !== 16'h0000) begin n_bad++; $display("FAIL illegal%0d_r0: got %h want 0000", v, dbg_data); end
      dbg_addr = 3'd1; #1;
      n_cmp++; if (dbg_data !== 16'h000A) begin n_bad++; $display("FAIL illegal%0d_r1: got %h want 000a", v, dbg_data); end
`ifdef ALU_ISSUE_FLAGS_EN
      n_cmp++; if ({flag_z, flag_c} !== 2'b11) begin n_bad++; $display("FAIL illegal%0d_flags: got %b want 11", v, {flag_z, flag_c}); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int acc_edge [3];
    int done_cyc [3];
    int n_acc, n_done;
    logic will_acc;
    n_acc = 0; n_done = 0;
    for (int i = 0; i < 3; i++) begin acc_edge[i] = -1; done_cyc[i] = -1; end
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 16'h0D01;                   // ADDI r5,#1, issued three times
    for (int c = 0; c < 16; c++) begin
      will_acc = instr_valid && instr_ready;
      @(posedge clk);
      if (will_acc) begin
        if (n_acc < 3) acc_edge[n_acc] = c;
        n_acc++;
      end
      @(negedge clk);
      if (done) begin
        if (n_done < 3) done_cyc[n_done] = c + 1;
        n_done++;
      end
      if (will_acc && n_acc >= 3) instr_valid = 1'b0;
    end
    n_cmp++; if (n_acc !== 3) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 3", n_acc); end
    n_cmp++; if ({acc_edge[0], acc_edge[1], acc_edge[2]} !== {32'sd0, 32'sd4, 32'sd8}) begin
      n_bad++; $display("FAIL b2b_accept_edges: got %0d %0d %0d want 0 4 8", acc_edge[0], acc_edge[1], acc_edge[2]); end
    n_cmp++; if (n_done !== 3) begin n_bad++; $display("FAIL b2b_dones: got %0d want 3", n_done); end
    n_cmp++; if ({done_cyc[0], done_cyc[1], done_cyc[2]} !== {32'sd3, 32'sd7, 32'sd11}) begin
      n_bad++; $display("FAIL b2b_done_cycles: got %0d %0d %0d want 3 7 11", done_cyc[0], done_cyc[1], done_cyc[2]); end
    dbg_addr = 3'd5; #1;
    n_cmp++; if (dbg_data !== 16'h0003) begin n_bad++; $display("FAIL b2b_r5: got %h want 0003", dbg_data); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_shift();
    test_zero();
    test_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
